// File: rtl/reg_writeback_queue.sv
// Write-back queue for the 16-entry register file: buffers (dest, data) results,
// drains one per cycle into the write port, and forwards queued values to decode.
module reg_writeback_queue #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_dest,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     wb_ready,
  output logic                     wb_we,
  output logic [ADDR_W-1:0]        wb_dest,
  output logic [XLEN-1:0]          wb_data,
  input  logic [ADDR_W-1:0]        src_one,
  input  logic [ADDR_W-1:0]        src_two,
  output logic                     fwd_hit_one,
  output logic [XLEN-1:0]          fwd_data_one,
  output logic                     fwd_hit_two,
  output logic [XLEN-1:0]          fwd_data_two,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [XLEN-1:0]   data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  // Writes to x0 complete the handshake but are never queued.
  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready && (in_dest != '0);
  assign pop      = wb_we && wb_ready;

  assign wb_we   = (count != '0);
  assign wb_dest = wb_we ? mem[rd_ptr].dest : '0;
  assign wb_data = wb_we ? mem[rd_ptr].data : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage has no reset; validity comes from count alone, so the
  // array can map onto plain flops or a register-file macro.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{dest: in_dest, data: in_data};
  end

  // NOTE: every output gets a default first so no latch is inferred.
  // Scanning oldest to youngest lets the last match (the youngest) win.
  always_comb begin
    fwd_hit_one  = 1'b0;
    fwd_data_one = '0;
    fwd_hit_two  = 1'b0;
    fwd_data_two = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if (src_one != '0 && mem[rd_ptr + PTR_W'(i)].dest == src_one) begin
          fwd_hit_one  = 1'b1;
          fwd_data_one = mem[rd_ptr + PTR_W'(i)].data;
        end
        if (src_two != '0 && mem[rd_ptr + PTR_W'(i)].dest == src_two) begin
          fwd_hit_two  = 1'b1;
          fwd_data_two = mem[rd_ptr + PTR_W'(i)].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed vector table, hand sequences for
// wrap/reset corners, and randomized traffic against a queue-based model.
module tb_reg_writeback_queue;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_dest;
  logic [XLEN-1:0]   in_data;
  logic              wb_ready;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_dest;
  logic [XLEN-1:0]   wb_data;
  logic [ADDR_W-1:0] src_one;
  logic [ADDR_W-1:0] src_two;
  logic              fwd_hit_one;
  logic [XLEN-1:0]   fwd_data_one;
  logic              fwd_hit_two;
  logic [XLEN-1:0]   fwd_data_two;
  logic [2:0]        count;

  reg_writeback_queue #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
    .wb_ready(wb_ready), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .src_one(src_one), .src_two(src_two),
    .fwd_hit_one(fwd_hit_one), .fwd_data_one(fwd_data_one),
    .fwd_hit_two(fwd_hit_two), .fwd_data_two(fwd_data_two),
    .count(count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [ADDR_W-1:0] dest;
    logic [XLEN-1:0]   data;
  } item_t;

  item_t model_q[$];

  typedef struct {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic [XLEN-1:0]   data;
    logic              wbr;
    logic [ADDR_W-1:0] s1;
    logic [ADDR_W-1:0] s2;
    logic              e_rdy;
    logic              e_we;
    logic [ADDR_W-1:0] e_dest;
    logic [XLEN-1:0]   e_data;
    logic [2:0]        e_cnt;
    logic              e_h1;
    logic [XLEN-1:0]   e_d1;
    logic              e_h2;
    logic [XLEN-1:0]   e_d2;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(input logic e_rdy, input logic e_we,
                             input logic [ADDR_W-1:0] e_dest, input logic [XLEN-1:0] e_data,
                             input logic [2:0] e_cnt, input logic e_h1, input logic [XLEN-1:0] e_d1,
                             input logic e_h2, input logic [XLEN-1:0] e_d2);
    check("in_ready",     64'(in_ready),     64'(e_rdy));
    check("wb_we",        64'(wb_we),        64'(e_we));
    check("wb_dest",      64'(wb_dest),      64'(e_dest));
    check("wb_data",      64'(wb_data),      64'(e_data));
    check("count",        64'(count),        64'(e_cnt));
    check("fwd_hit_one",  64'(fwd_hit_one),  64'(e_h1));
    check("fwd_data_one", 64'(fwd_data_one), 64'(e_d1));
    check("fwd_hit_two",  64'(fwd_hit_two),  64'(e_h2));
    check("fwd_data_two", 64'(fwd_data_two), 64'(e_d2));
  endtask

  // Youngest queued value for a register, searching back from the tail.
  task automatic model_lookup(input logic [ADDR_W-1:0] src, output logic hit, output logic [XLEN-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (src != '0) begin
      for (int i = model_q.size() - 1; i >= 0; i--) begin
        if (model_q[i].dest == src) begin
          hit  = 1'b1;
          data = model_q[i].data;
          break;
        end
      end
    end
  endtask

  task automatic model_check();
    logic              h1, h2;
    logic [XLEN-1:0]   d1, d2;
    logic              busy;
    busy = (model_q.size() != 0);
    model_lookup(src_one, h1, d1);
    model_lookup(src_two, h2, d2);
    compare_all(model_q.size() != DEPTH, busy,
                busy ? model_q[0].dest : '0, busy ? model_q[0].data : '0,
                3'(model_q.size()), h1, d1, h2, d2);
  endtask

  // Apply one clock edge to the model using the inputs held across it.
  task automatic model_advance();
    logic do_pop, do_push;
    do_pop  = (model_q.size() != 0) && wb_ready;
    do_push = in_valid && (model_q.size() != DEPTH) && (in_dest != '0);
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back('{dest: in_dest, data: in_data});
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] d, input logic [XLEN-1:0] da,
                       input logic wr, input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2);
    in_valid = v; in_dest = d; in_data = da; wb_ready = wr; src_one = s1; src_two = s2;
  endtask

  task automatic mtick(input logic v, input logic [ADDR_W-1:0] d, input logic [XLEN-1:0] da,
                       input logic wr, input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2);
    drive(v, d, da, wr, s1, s2);
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // valid dest data wbr s1 s2 | rdy we wdest wdata cnt h1 d1 h2 d2
    vecs[0]  = '{1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd5, 4'd0, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 3'd1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 4'd0, 32'h1234,     1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{1'b1, 4'd1, 32'h11,       1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[5]  = '{1'b1, 4'd2, 32'h22,       1'b0, 4'd1, 4'd0, 1'b1, 1'b1, 4'd1, 32'h11,       3'd1, 1'b1, 32'h11,       1'b0, 32'h0};
    vecs[6]  = '{1'b1, 4'd3, 32'h33,       1'b0, 4'd2, 4'd0, 1'b1, 1'b1, 4'd1, 32'h11,       3'd2, 1'b1, 32'h22,       1'b0, 32'h0};
    vecs[7]  = '{1'b1, 4'd4, 32'h44,       1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1, 32'h11,       3'd3, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[8]  = '{1'b1, 4'd5, 32'h55,       1'b0, 4'd4, 4'd5, 1'b0, 1'b1, 4'd1, 32'h11,       3'd4, 1'b1, 32'h44,       1'b0, 32'h0};
    vecs[9]  = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd0, 4'd5, 1'b0, 1'b1, 4'd1, 32'h11,       3'd4, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[10] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd1, 4'd0, 1'b1, 1'b1, 4'd2, 32'h22,       3'd3, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[11] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd3, 32'h33,       3'd2, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[12] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd4, 32'h44,       3'd1, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[13] = '{1'b1, 4'd7, 32'hA,        1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[14] = '{1'b1, 4'd7, 32'hB,        1'b0, 4'd7, 4'd0, 1'b1, 1'b1, 4'd7, 32'hA,        3'd1, 1'b1, 32'hA,        1'b0, 32'h0};
    vecs[15] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd7, 4'd3, 1'b1, 1'b1, 4'd7, 32'hA,        3'd2, 1'b1, 32'hB,        1'b0, 32'h0};
    vecs[16] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd7, 32'hA,        3'd2, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[17] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd7, 4'd0, 1'b1, 1'b1, 4'd7, 32'hB,        3'd1, 1'b1, 32'hB,        1'b0, 32'h0};
    vecs[18] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};

    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 4'd3, 4'd9);
    #2;
    model_check();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: reset/latency, x0 discard, full stall, drain order, youngest forwarding.
    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].dest, vecs[i].data, vecs[i].wbr, vecs[i].s1, vecs[i].s2);
      @(negedge clk);
      compare_all(vecs[i].e_rdy, vecs[i].e_we, vecs[i].e_dest, vecs[i].e_data, vecs[i].e_cnt,
                  vecs[i].e_h1, vecs[i].e_d1, vecs[i].e_h2, vecs[i].e_d2);
      @(posedge clk);
      model_advance();
      #1;
    end

    // Wrap and concurrency: a push every cycle with wb_ready alternating.
    for (int k = 0; k < 10; k++)
      mtick(1'b1, ADDR_W'(k + 1), $urandom, (k % 2) == 0, ADDR_W'(k), ADDR_W'(k + 1));
    for (int k = 0; k < 8 && model_q.size() != 0; k++)
      mtick(1'b0, '0, '0, 1'b1, 4'd9, 4'd10);
    check("drain_empty", 64'(count), 64'(0));

    // Asynchronous reset with three entries queued.
    mtick(1'b1, 4'd1, 32'h101, 1'b0, 4'd0, 4'd0);
    mtick(1'b1, 4'd2, 32'h102, 1'b0, 4'd0, 4'd0);
    mtick(1'b1, 4'd3, 32'h103, 1'b0, 4'd0, 4'd0);
    mtick(1'b0, '0, '0, 1'b0, 4'd2, 4'd0);
    check("pre_reset_count", 64'(count), 64'(3));
    drive(1'b0, '0, '0, 1'b0, 4'd2, 4'd3);
    #2;
    reset = 1'b0;
    #1;
    check("async_wb_we", 64'(wb_we), 64'(0));
    check("async_count", 64'(count), 64'(0));
    check("async_hit",   64'(fwd_hit_one), 64'(0));
    model_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_advance();
    #1;
    mtick(1'b1, 4'd9, 32'h55, 1'b1, 4'd9, 4'd0);
    mtick(1'b0, '0, '0, 1'b1, 4'd9, 4'd1);
    mtick(1'b0, '0, '0, 1'b1, 4'd9, 4'd1);

    // Randomized traffic against the queue model.
    for (int k = 0; k < 400; k++)
      mtick(1'($urandom), ADDR_W'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 2) != 0),
            ADDR_W'($urandom_range(0, 15)), ADDR_W'($urandom_range(0, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
